mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
`default_nettype none
//==============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage. Holds one instruction from the
//               execute stage, waits for the load response if it is a load,
//               extracts and extends the addressed byte/halfword/word, and
//               hands the result to the write-back stage. Also drives bypass
//               and hazard information back to the decode stage.
// Options     : MS_FWD_EN - when defined, ms_to_ds_fwd_bus carries live
//               forwarding information; when undefined it is tied to zero.
// Revision    : 1.0 - initial release
//==============================================================================

`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 74
`endif
`ifndef MS_TO_WS_BUS_WD
`define MS_TO_WS_BUS_WD 70
`endif
`ifndef MS_TO_DS_FWD_BUS_WD
`define MS_TO_DS_FWD_BUS_WD 39
`endif

module mem_stage (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ws_allowin,
    output logic                            ms_allowin,
    input  logic                            es_to_ms_valid,
    input  logic [`ES_TO_MS_BUS_WD-1:0]     es_to_ms_bus,
    input  logic                            data_sram_data_ok,
    input  logic [31:0]                     data_sram_rdata,
    output logic                            ms_to_ws_valid,
    output logic [`MS_TO_WS_BUS_WD-1:0]     ms_to_ws_bus,
    output logic [`MS_TO_DS_FWD_BUS_WD-1:0] ms_to_ds_fwd_bus
);

    // Stage occupancy: EMPTY (no instruction), WAIT (load awaiting its
    // response), DONE (result available, waiting for write-back to take it).
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // Position of mem_re inside the incoming execute-stage bus.
    localparam int c_MEM_RE_BIT = 41;

    // Load type encodings; anything not listed behaves as a full word.
    localparam logic [2:0] c_LT_LB  = 3'd1;
    localparam logic [2:0] c_LT_LBU = 3'd2;
    localparam logic [2:0] c_LT_LH  = 3'd3;
    localparam logic [2:0] c_LT_LHU = 3'd4;

    logic [1:0]                    r_state;
    logic [1:0]                    w_state_nxt;
    logic                          r_ms_valid;
    logic [`ES_TO_MS_BUS_WD-1:0]   r_es_bus;
    logic [31:0]                   r_load_buf;

    logic [31:0]                   w_pc;
    logic                          w_mem_re;
    logic [2:0]                    w_load_type;
    logic                          w_rf_we;
    logic [4:0]                    w_rf_waddr;
    logic [31:0]                   w_alu_result;
    logic [1:0]                    w_offset;

    logic                          w_ms_ready_go;
    logic                          w_accept;
    logic                          w_leave;
    logic                          w_in_mem_re;
    logic                          w_resp_taken;
    logic [31:0]                   w_load_word;
    logic [7:0]                    w_byte;
    logic [15:0]                   w_half;
    logic [31:0]                   w_load_data;
    logic [31:0]                   w_rf_wdata;

    assign {w_pc, w_mem_re, w_load_type, w_rf_we, w_rf_waddr, w_alu_result} = r_es_bus;
    assign w_offset    = w_alu_result[1:0];
    assign w_in_mem_re = es_to_ms_bus[c_MEM_RE_BIT];

    // A response only counts while a load is actually outstanding; responses
    // seen in EMPTY or DONE are stray and are dropped.
    assign w_resp_taken = (r_state == c_ST_WAIT) && data_sram_data_ok;

    // The result is ready in DONE, or in WAIT on the response cycle so the
    // load can leave without an extra bubble.
    assign w_ms_ready_go = (r_state == c_ST_DONE) || w_resp_taken;

    assign ms_allowin     = !r_ms_valid || (w_ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go;
    assign w_accept       = ms_allowin && es_to_ms_valid;
    assign w_leave        = r_ms_valid && w_ms_ready_go && ws_allowin;

    // Next-state selection: a new accept overrides everything, otherwise the
    // current instruction either leaves, completes its load, or holds.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = w_in_mem_re ? c_ST_WAIT : c_ST_DONE;
                end
            end
            c_ST_WAIT, c_ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_in_mem_re ? c_ST_WAIT : c_ST_DONE;
                end else if (w_leave) begin
                    w_state_nxt = c_ST_EMPTY;
                end else if (w_resp_taken) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Valid flag follows the upstream valid whenever the stage can accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es_to_ms_valid;
        end
    end

    // Payload register captures only real accepts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_es_bus <= '0;
        end else if (w_accept) begin
            r_es_bus <= es_to_ms_bus;
        end
    end

    // Load buffer keeps the response while write-back back-pressures us.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load_buf <= 32'h0;
        end else if (w_resp_taken) begin
            r_load_buf <= data_sram_rdata;
        end
    end

    // In WAIT the live response is used directly; afterwards the buffer.
    assign w_load_word = (r_state == c_ST_WAIT) ? data_sram_rdata : r_load_buf;

    // Byte/halfword selection by address offset and sign/zero extension.
    always_comb begin
        w_byte = w_load_word[7:0];
        case (w_offset)
            2'd0:    w_byte = w_load_word[7:0];
            2'd1:    w_byte = w_load_word[15:8];
            2'd2:    w_byte = w_load_word[23:16];
            default: w_byte = w_load_word[31:24];
        endcase
        w_half = w_offset[1] ? w_load_word[31:16] : w_load_word[15:0];
        case (w_load_type)
            c_LT_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_LT_LBU: w_load_data = {24'h0, w_byte};
            c_LT_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_LT_LHU: w_load_data = {16'h0, w_half};
            default:  w_load_data = w_load_word;
        endcase
    end

    assign w_rf_wdata   = w_mem_re ? w_load_data : w_alu_result;
    assign ms_to_ws_bus = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};

`ifdef MS_FWD_EN
    // Bypass info: fwd_ready low means the decode stage must stall on a
    // dependence because the load value is not yet available.
    assign ms_to_ds_fwd_bus = {r_ms_valid && w_rf_we, w_ms_ready_go, w_rf_waddr, w_rf_wdata};
`else
    assign ms_to_ds_fwd_bus = '0;
`endif

endmodule

`default_nettype wire
